stn_cap_wr: RTL and testbench

STN_CAP_WR -- requirements
Module: stn_cap_wr

---
 rtl/stn_cap_wr.sv | 119 +++++++++++
 tb/tb_stn_cap_wr.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stn_cap_wr.sv
// rtl/stn_cap_wr.sv - STN panel capture: nibble packer and buffer writer sharing one RAM port with the TFT reader
module stn_cap_wr #(
  parameter logic [12:0] ADDR_LAST = 13'h17BF
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        stn_fpframe,
  input  logic        stn_fpline,
  input  logic        stn_fpshift,
  input  logic [3:0]  stn_fpdat,
  input  logic        fifo_rdreq,
  input  logic [12:0] fifo_raddr,
  output logic        fifo_rdack,
  output logic [7:0]  fifo_rdata,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        cap_ovf,
  output logic [7:0]  cap_line,
  output logic        cap_frame_done
);

  logic       shift_s1, shift_s2, shift_d;
  logic       line_s1, line_s2, line_d;
  logic       frame_s1, frame_s2, frame_d;
  logic [3:0] dat_s1, dat_s2;

  // Pixel data rides through the same two flops as the strobes so it stays aligned with the shift edge.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      shift_s1 <= 1'b0;
      shift_s2 <= 1'b0;
      shift_d  <= 1'b0;
      line_s1  <= 1'b0;
      line_s2  <= 1'b0;
      line_d   <= 1'b0;
      frame_s1 <= 1'b0;
      frame_s2 <= 1'b0;
      frame_d  <= 1'b0;
      dat_s1   <= 4'h0;
      dat_s2   <= 4'h0;
    end else begin
      shift_s1 <= stn_fpshift;
      shift_s2 <= shift_s1;
      shift_d  <= shift_s2;
      line_s1  <= stn_fpline;
      line_s2  <= line_s1;
      line_d   <= line_s2;
      frame_s1 <= stn_fpframe;
      frame_s2 <= frame_s1;
      frame_d  <= frame_s2;
      dat_s1   <= stn_fpdat;
      dat_s2   <= dat_s1;
    end
  end

  logic shift_fall;
  logic line_fall;

  assign shift_fall = shift_d & ~shift_s2;
  assign line_fall  = line_d & ~line_s2;

  logic        phase;
  logic [3:0]  hi_nib;
  logic        wr_pend;
  logic [7:0]  wr_byte;
  logic [12:0] wr_addr;

  // frame_d is the frame level seen alongside line_d, i.e. while the line pulse was still high.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      phase          <= 1'b0;
      hi_nib         <= 4'h0;
      wr_pend        <= 1'b0;
      wr_byte        <= 8'h00;
      wr_addr        <= 13'h0000;
      cap_line       <= 8'h00;
      cap_ovf        <= 1'b0;
      cap_frame_done <= 1'b0;
    end else begin
      cap_frame_done <= 1'b0;
      if (wr_pend) begin
        wr_pend <= 1'b0;
        wr_addr <= (wr_addr == ADDR_LAST) ? 13'h0000 : wr_addr + 13'd1;
      end
      if (line_fall) begin
        phase <= 1'b0;
        if (frame_d) begin
          wr_addr        <= 13'h0000;
          cap_line       <= 8'h00;
          cap_frame_done <= 1'b1;
        end else if (cap_line != 8'hFF) begin
          cap_line <= cap_line + 8'd1;
        end
      end else if (shift_fall) begin
        if (!phase) begin
          hi_nib <= dat_s2;
          phase  <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (wr_pend) begin
            cap_ovf <= 1'b1;
          end else begin
            wr_pend <= 1'b1;
            wr_byte <= {hi_nib, dat_s2};
          end
        end
      end
    end
  end

  assign fifo_rdack = fifo_rdreq & ~wr_pend;
  assign ram_we     = wr_pend;
  assign ram_addr   = wr_pend ? wr_addr : fifo_raddr;
  assign ram_wdata  = wr_byte;
  assign fifo_rdata = ram_rdata;

endmodule

// File: tb/tb_stn_cap_wr.sv
// tb/tb_stn_cap_wr.sv - directed bench for stn_cap_wr with a write scoreboard and a behavioural RAM
module tb_stn_cap_wr;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        stn_fpframe, stn_fpline, stn_fpshift;
  logic [3:0]  stn_fpdat;
  logic        fifo_rdreq;
  logic [12:0] fifo_raddr;
  logic        fifo_rdack;
  logic [7:0]  fifo_rdata;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        cap_ovf;
  logic [7:0]  cap_line;
  logic        cap_frame_done;

  stn_cap_wr dut (
    .clk(clk), .rst_x(rst_x),
    .stn_fpframe(stn_fpframe), .stn_fpline(stn_fpline),
    .stn_fpshift(stn_fpshift), .stn_fpdat(stn_fpdat),
    .fifo_rdreq(fifo_rdreq), .fifo_raddr(fifo_raddr),
    .fifo_rdack(fifo_rdack), .fifo_rdata(fifo_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cap_ovf(cap_ovf), .cap_line(cap_line), .cap_frame_done(cap_frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int          checks = 0;
  int          failures = 0;
  logic [20:0] exp_q [$];
  logic [12:0] exp_waddr = 13'h0000;
  logic [12:0] last_waddr = 13'h0000;
  logic        mon_en = 1'b1;
  int          fd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_nib(input logic [3:0] n);
    stn_fpdat   = n;
    stn_fpshift = 1'b1;
    step(2);
    stn_fpshift = 1'b0;
    step(2);
  endtask

  task automatic line_pulse(input logic frm);
    stn_fpframe = frm;
    stn_fpline  = 1'b1;
    step(2);
    stn_fpline  = 1'b0;
    step(4);
    stn_fpframe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back({exp_waddr, b});
    exp_waddr = (exp_waddr == 13'h17BF) ? 13'h0000 : exp_waddr + 13'd1;
    shift_nib(b[7:4]);
    shift_nib(b[3:0]);
  endtask

  always @(negedge clk) begin
    if (rst_x && cap_frame_done) fd_cnt++;
    if (rst_x && mon_en && ram_we) begin
      last_waddr = ram_addr;
      if (exp_q.size() == 0) begin
        chk("write_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("write_addr_data", 32'({ram_addr, ram_wdata}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int fd0;
    rst_x = 1'b0;
    stn_fpframe = 1'b0; stn_fpline = 1'b0; stn_fpshift = 1'b0; stn_fpdat = 4'h0;
    fifo_rdreq = 1'b1; fifo_raddr = 13'h0000;
    step(3);
    chk("rst_rdack", fifo_rdack, 1);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_cap_line", cap_line, 0);
    chk("rst_cap_ovf", cap_ovf, 0);
    chk("rst_frame_done", cap_frame_done, 0);

    rst_x = 1'b1;
    fifo_rdreq = 1'b0;
    fifo_raddr = 13'h0123;
    step(2);
    chk("idle_ram_addr", ram_addr, 13'h0123);
    chk("idle_ram_we", ram_we, 0);

    line_pulse(1'b0);
    chk("line_count_1", cap_line, 1);
    send_byte(8'hA5);
    step(4);
    chk("a5_written", 32'(exp_q.size()), 0);

    fifo_raddr = 13'h0000;
    fifo_rdreq = 1'b1;
    exp_q.push_back({exp_waddr, 8'h12});
    exp_waddr = exp_waddr + 13'd1;
    fork
      begin
        shift_nib(4'h1);
        shift_nib(4'h2);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          step(1);
          if (ram_we) break;
        end
        chk("rd_saw_write", ram_we, 1);
        chk("rd_ack_blocked", fifo_rdack, 0);
        step(1);
        chk("rd_ack_next", fifo_rdack, 1);
        step(1);
        chk("rd_data", fifo_rdata, 8'hA5);
      end
    join
    fifo_rdreq = 1'b0;
    step(4);

    shift_nib(4'h7);
    line_pulse(1'b0);
    send_byte(8'h3C);
    step(4);
    chk("partial_line_count", cap_line, 2);

    shift_nib(4'h9);
    rst_x = 1'b0;
    step(2);
    rst_x = 1'b1;
    exp_waddr = 13'h0000;
    chk("midline_rst_line", cap_line, 0);
    send_byte(8'h6E);
    step(4);

    for (int i = 0; i < 100; i++) line_pulse(1'b0);
    chk("line_count_100", cap_line, 100);
    fd0 = fd_cnt;
    line_pulse(1'b1);
    exp_waddr = 13'h0000;
    chk("frame_line_clr", cap_line, 0);
    chk("frame_done_once", 32'(fd_cnt - fd0), 1);
    send_byte(8'h4B);
    step(4);

    for (int i = 0; i < 260; i++) line_pulse(1'b0);
    chk("line_saturate", cap_line, 8'hFF);

    line_pulse(1'b1);
    exp_waddr = 13'h0000;
    for (int i = 0; i < 6080; i++) send_byte(8'($urandom_range(0, 255)));
    step(4);
    chk("wrap_last_addr", last_waddr, 13'h17BF);
    send_byte(8'h5A);
    step(4);
    chk("wrap_first_addr", last_waddr, 13'h0000);
    chk("no_ovf_full_rate", cap_ovf, 0);

    mon_en = 1'b0;
    force dut.wr_pend = 1'b1;
    shift_nib(4'h1);
    shift_nib(4'h2);
    step(4);
    chk("ovf_set", cap_ovf, 1);
    release dut.wr_pend;
    step(3);
    mon_en = 1'b1;
    step(20);
    chk("ovf_sticky", cap_ovf, 1);
    rst_x = 1'b0;
    step(1);
    chk("ovf_rst_clr", cap_ovf, 0);
    rst_x = 1'b1;
    step(2);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
